// File: rtl/mdu_stage.sv
// mdu_stage: iterative multiply/divide unit sitting beside the ALU in Execute.
// It computes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles into the architectural
// HI/LO registers, services MTHI/MTLO moves, and requests a decode stall while
// a result is still being produced.
module mdu_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             mthiE,
  input  logic             mtloE,
  input  logic             flushE,
  input  logic             hiloD,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stallmduD
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   counter;
  logic               isDiv;
  logic               negRes;
  logic               negRem;
  logic               divZero;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   dividendRaw;
  logic [2*WIDTH-1:0] acc;

  // Magnitude of an operand; unsigned ops pass straight through.
  function automatic logic [WIDTH-1:0] absVal(input logic signed [WIDTH-1:0] v,
                                              input logic isSigned);
    return (isSigned && v[WIDTH-1]) ? -v : v;
  endfunction

  // Conditional two's-complement negate of a single-width result.
  function automatic logic [WIDTH-1:0] condNegW(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? -v : v;
  endfunction

  // Conditional two's-complement negate of a double-width product.
  function automatic logic [2*WIDTH-1:0] condNeg2W(input logic [2*WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? -v : v;
  endfunction

  logic               signedOp;
  logic               start;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic [2*WIDTH-1:0] accStep;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;

  assign signedOp = ~opE[0];
  assign start    = startE & ~flushE;
  assign magA     = absVal(srcaE, signedOp);
  assign magB     = absVal(srcbE, signedOp);

  // acc holds {upper, lower}: for multiply {partial product, remaining multiplier},
  // for divide {partial remainder, dividend bits shifting into quotient bits}.
  assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, opnd};

  // One radix-2 step: shift-add multiply or restoring divide.
  always_comb begin
    accStep = {mulSum, acc[WIDTH-1:1]};
    if (isDiv) begin
      if (divDiff[WIDTH])
        accStep = {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        accStep = {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  assign prodFix = condNeg2W(acc, negRes);
  assign quoFix  = condNegW(acc[WIDTH-1:0], negRes);
  assign remFix  = condNegW(acc[2*WIDTH-1:WIDTH], negRem);

  // Control FSM, iteration datapath and architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      isDiv       <= 1'b0;
      negRes      <= 1'b0;
      negRem      <= 1'b0;
      divZero     <= 1'b0;
      opnd        <= '0;
      dividendRaw <= '0;
      acc         <= '0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            isDiv       <= opE[1];
            negRes      <= signedOp & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            negRem      <= signedOp & srcaE[WIDTH-1];
            divZero     <= (srcbE == '0);
            dividendRaw <= srcaE;
            opnd        <= opE[1] ? magB : magA;
            acc         <= {{WIDTH{1'b0}}, (opE[1] ? magA : magB)};
            counter     <= '0;
            state       <= RUN;
          end else if (!flushE) begin
            if (mthiE) hi <= srcaE;
            if (mtloE) lo <= srcaE;
          end
        end
        RUN: begin
          acc     <= accStep;
          counter <= counter + 1'b1;
          if (counter == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (!isDiv) begin
            hi <= prodFix[2*WIDTH-1:WIDTH];
            lo <= prodFix[WIDTH-1:0];
          end else if (divZero) begin
            hi <= dividendRaw;
            lo <= '1;
          end else begin
            hi <= remFix;
            lo <= quoFix;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign stallmduD = busy & hiloD;

endmodule

// File: tb/tb_mdu_stage.sv
// Directed bench for mdu_stage: operations are queued with their expected
// HI/LO when issued and compared when the unit goes idle again.
module tb_mdu_stage;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             startE, mthiE, mtloE, flushE, hiloD;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE, srcbE;
  logic [WIDTH-1:0] hi, lo;
  logic             busy, stallmduD;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  mdu_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .startE(startE), .opE(opE), .srcaE(srcaE),
    .srcbE(srcbE), .mthiE(mthiE), .mtloE(mtloE), .flushE(flushE),
    .hiloD(hiloD), .hi(hi), .lo(lo), .busy(busy), .stallmduD(stallmduD)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // inj: 0 none, 1 moves asserted while busy, 2 moves asserted together with start
  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi,
                       input logic [31:0] expLo, input logic hd, input int inj);
    logic [31:0] pHi, pLo;
    logic [63:0] e;
    int cyc;
    @(negedge clk);
    pHi = hi; pLo = lo;
    startE = 1'b1; opE = op; srcaE = a; srcbE = b; hiloD = hd;
    mthiE = (inj == 2); mtloE = (inj == 2);
    sb.push_back({expHi, expLo});
    @(negedge clk);
    startE = 1'b0; mthiE = 1'b0; mtloE = 1'b0;
    check({tag, ".busyStart"}, {31'b0, busy}, 32'd1);
    cyc = 0;
    while (busy && cyc < 100) begin
      if (inj == 1 && cyc == 3) begin
        mthiE = 1'b1; mtloE = 1'b1; srcaE = 32'h1111_2222;
      end else begin
        mthiE = 1'b0; mtloE = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (busy) begin
        check({tag, ".hiHold"}, hi, pHi);
        check({tag, ".loHold"}, lo, pLo);
        if (hd) check({tag, ".stall"}, {31'b0, stallmduD}, 32'd1);
      end
    end
    mthiE = 1'b0; mtloE = 1'b0;
    check({tag, ".latency"}, 32'(cyc), 32'(WIDTH + 1));
    check({tag, ".stallIdle"}, {31'b0, stallmduD}, 32'd0);
    e = sb.pop_front();
    check({tag, ".hi"}, hi, e[63:32]);
    check({tag, ".lo"}, lo, e[31:0]);
    hiloD = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb, pHi, pLo;
    logic [63:0] prod;
    logic signed [63:0] sa, sbv, sp;

    reset = 1'b1; startE = 1'b0; opE = 2'b00; srcaE = '0; srcbE = '0;
    mthiE = 1'b0; mtloE = 1'b0; flushE = 1'b0; hiloD = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.hi", hi, 32'h0);
    check("rst.lo", lo, 32'h0);
    check("rst.busy", {31'b0, busy}, 32'd0);
    check("rst.stall", {31'b0, stallmduD}, 32'd0);
    reset = 1'b0; hiloD = 1'b0;

    runOp("mult", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1, 0);
    runOp("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    runOp("divNeg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    runOp("divOvf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 0);
    runOp("divuZero", 2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b0, 0);
    runOp("divZeroNeg", 2'b10, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, 0);
    runOp("divNegDivisor", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 0);
    runOp("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1);
    runOp("startWins", 2'b01, 32'd6, 32'd9, 32'd0, 32'd54, 1'b0, 2);

    for (int i = 0; i < 2; i++) begin
      ra = $urandom; rb = $urandom;
      prod = 64'(ra) * 64'(rb);
      runOp("multuRnd", 2'b01, ra, rb, prod[63:32], prod[31:0], 1'b0, 0);
      rb = $urandom_range(1, 32'h00FF_FFFF);
      runOp("divuRnd", 2'b11, ra, rb, ra % rb, ra / rb, 1'b0, 0);
      sa = $signed(ra); sbv = $signed(rb ^ 32'h8000_0000);
      sp = sa * sbv;
      runOp("multRnd", 2'b00, ra, rb ^ 32'h8000_0000, sp[63:32], sp[31:0], 1'b0, 0);
    end

    // Flushed start must not launch an operation.
    @(negedge clk);
    pHi = hi; pLo = lo;
    startE = 1'b1; flushE = 1'b1; opE = 2'b00; srcaE = 32'd5; srcbE = 32'd5;
    @(negedge clk);
    startE = 1'b0; flushE = 1'b0;
    check("flush.busy", {31'b0, busy}, 32'd0);
    check("flush.hi", hi, pHi);
    check("flush.lo", lo, pLo);

    // MTHI / MTLO in idle, and a flushed move.
    mthiE = 1'b1; srcaE = 32'h0000_A5A5;
    @(negedge clk);
    mthiE = 1'b0;
    check("mthi.hi", hi, 32'h0000_A5A5);
    check("mthi.lo", lo, pLo);
    mtloE = 1'b1; srcaE = 32'h0000_5A5A;
    @(negedge clk);
    mtloE = 1'b0;
    check("mtlo.lo", lo, 32'h0000_5A5A);
    mtloE = 1'b1; flushE = 1'b1; srcaE = 32'hDEAD_BEEF;
    @(negedge clk);
    mtloE = 1'b0; flushE = 1'b0;
    check("mtloFlush.lo", lo, 32'h0000_5A5A);
    hiloD = 1'b1;
    #1 check("idleStall", {31'b0, stallmduD}, 32'd0);
    hiloD = 1'b0;

    // Reset during RUN aborts with cleared HI/LO.
    @(negedge clk);
    startE = 1'b1; opE = 2'b00; srcaE = 32'd5; srcbE = 32'd6;
    @(negedge clk);
    startE = 1'b0;
    repeat (10) @(negedge clk);
    check("abort.busyBefore", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort.busy", {31'b0, busy}, 32'd0);
    check("abort.hi", hi, 32'h0);
    check("abort.lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    runOp("afterAbort", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0);

    check("sbEmpty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
